// File: rtl/pong_score_ctrl.sv
// pong_score_ctrl: game-state controller for AR pong.
// Counts goals, sequences SERVE -> PLAY -> (SERVE | OVER), latches the
// winner and presents it to the overlay only on frame boundaries.
// Optional feature: define PONG_AUTO_RESTART_EN to leave OVER automatically
// on the frame_tick after the minimum OVER hold time has elapsed.
module pong_score_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int PAUSE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick_i,
  input  logic       goal_p1_i,
  input  logic       goal_p2_i,
  input  logic       restart_i,
  output logic [3:0] score_p1_o,
  output logic [3:0] score_p2_o,
  output logic       serve_o,
  output logic       game_active_o,
  output logic       p1w_o,
  output logic       p2w_o
);

  localparam int CNT_MAX = (PAUSE_FRAMES > OVER_FRAMES) ? PAUSE_FRAMES : OVER_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_HOLD  = CNT_W'(OVER_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]       WIN_VAL    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]       score_p1_q, score_p1_d;
  logic [3:0]       score_p2_q, score_p2_d;
  logic             pend_p1_q, pend_p1_d;
  logic             pend_p2_q, pend_p2_d;
  logic             p1w_q, p2w_q;
  logic             goal_p1_dly_q, goal_p2_dly_q, restart_dly_q;

  logic             rise_p1, rise_p2, rise_restart;
  logic             over_done, restart_now;
  logic [3:0]       score_p1_inc, score_p2_inc;

  // Rising-edge detection: a held level produces exactly one event.
  assign rise_p1      = goal_p1_i & ~goal_p1_dly_q;
  assign rise_p2      = goal_p2_i & ~goal_p2_dly_q;
  assign rise_restart = restart_i & ~restart_dly_q;

  assign score_p1_inc = score_p1_q + 4'd1;
  assign score_p2_inc = score_p2_q + 4'd1;
  assign over_done    = (frame_cnt_q == OVER_HOLD);

  // Input edge registers, sampled every cycle regardless of state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (!rst_n) begin
      goal_p1_dly_q <= 1'b0;
      goal_p2_dly_q <= 1'b0;
      restart_dly_q <= 1'b0;
    end else begin
      goal_p1_dly_q <= goal_p1_i;
      goal_p2_dly_q <= goal_p2_i;
      restart_dly_q <= restart_i;
    end
  end

  // Game state register: FSM state, frame counter, scores, pending winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_SERVE;
      frame_cnt_q <= '0;
      score_p1_q  <= 4'd0;
      score_p2_q  <= 4'd0;
      pend_p1_q   <= 1'b0;
      pend_p2_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      pend_p1_q   <= pend_p1_d;
      pend_p2_q   <= pend_p2_d;
    end
  end

  // Next-state and Moore/Mealy outputs for SERVE / PLAY / OVER.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    frame_cnt_d   = frame_cnt_q;
    score_p1_d    = score_p1_q;
    score_p2_d    = score_p2_q;
    pend_p1_d     = pend_p1_q;
    pend_p2_d     = pend_p2_q;
    serve_o       = 1'b0;
    game_active_o = 1'b0;
    restart_now   = 1'b0;

    case (state_q)
      ST_SERVE: begin
        if (frame_tick_i) begin
          if (frame_cnt_q == PAUSE_LAST) begin
            serve_o     = 1'b1;
            frame_cnt_d = '0;
            state_d     = ST_PLAY;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_ONE;
          end
        end
      end

      ST_PLAY: begin
        game_active_o = 1'b1;
        if (rise_p1 && rise_p2) begin
          // Simultaneous goals are a dead ball: re-serve with no score change.
          state_d = ST_SERVE;
        end else if (rise_p1) begin
          score_p1_d = score_p1_inc;
          if (score_p1_inc == WIN_VAL) begin
            state_d   = ST_OVER;
            pend_p1_d = 1'b1;
          end else begin
            state_d = ST_SERVE;
          end
        end else if (rise_p2) begin
          score_p2_d = score_p2_inc;
          if (score_p2_inc == WIN_VAL) begin
            state_d   = ST_OVER;
            pend_p2_d = 1'b1;
          end else begin
            state_d = ST_SERVE;
          end
        end
      end

      ST_OVER: begin
`ifdef PONG_AUTO_RESTART_EN
        restart_now = over_done & (rise_restart | frame_tick_i);
`else
        restart_now = over_done & rise_restart;
`endif
        if (restart_now) begin
          score_p1_d  = 4'd0;
          score_p2_d  = 4'd0;
          frame_cnt_d = '0;
          pend_p1_d   = 1'b0;
          pend_p2_d   = 1'b0;
          state_d     = ST_SERVE;
        end else if (frame_tick_i && !over_done) begin
          // Saturates at the hold time; early restart rises are simply dropped.
          frame_cnt_d = frame_cnt_q + CNT_ONE;
        end
      end

      default: state_d = ST_SERVE;
    endcase
  end

  // Overlay flags follow the pending winner only at frame boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1w_q <= 1'b0;
      p2w_q <= 1'b0;
    end else if (frame_tick_i) begin
      p1w_q <= pend_p1_q;
      p2w_q <= pend_p2_q;
    end
  end

  assign score_p1_o = score_p1_q;
  assign score_p2_o = score_p2_q;
  assign p1w_o      = p1w_q;
  assign p2w_o      = p2w_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// tb_pong_score_ctrl: directed scenarios followed by randomized play, every
// cycle compared against a behavioural game model kept in this bench.
module tb_pong_score_ctrl;

  localparam int WIN   = 7;
  localparam int PAUSE = 60;
  localparam int OVER  = 180;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ft = 1'b0, g1 = 1'b0, g2 = 1'b0, rs = 1'b0;
  logic [3:0] s_p1, s_p2;
  logic       serve_w, active_w, p1w_w, p2w_w;

  int total = 0;
  int bad   = 0;
  int serve_seen = 0;

  // Behavioural model of the game.
  int m_s1, m_s2;      // scores
  int m_frames;        // frames counted in the current waiting/finished phase
  bit m_rally;         // ball in play
  bit m_won;           // game finished, waiting for restart
  int m_pending;       // winner decided: 0 none, 1 = P1, 2 = P2
  int m_shown;         // winner shown on overlay
  bit m_pg1, m_pg2, m_prs;

  pong_score_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick_i (ft),
    .goal_p1_i    (g1),
    .goal_p2_i    (g2),
    .restart_i    (rs),
    .score_p1_o   (s_p1),
    .score_p2_o   (s_p2),
    .serve_o      (serve_w),
    .game_active_o(active_w),
    .p1w_o        (p1w_w),
    .p2w_o        (p2w_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_frames = 0;
    m_rally = 0; m_won = 0; m_pending = 0; m_shown = 0;
    m_pg1 = 0; m_pg2 = 0; m_prs = 0;
  endtask

  task automatic model_advance(input bit f, input bit a, input bit b, input bit r);
    bit r1, r2, rr;
    r1 = a && !m_pg1;
    r2 = b && !m_pg2;
    rr = r && !m_prs;
    if (f) m_shown = m_pending;
    if (m_won) begin
`ifdef PONG_AUTO_RESTART_EN
      if (m_frames == OVER && (rr || f)) begin
`else
      if (m_frames == OVER && rr) begin
`endif
        m_s1 = 0; m_s2 = 0; m_frames = 0; m_pending = 0; m_won = 0;
      end else if (f && m_frames < OVER) begin
        m_frames++;
      end
    end else if (m_rally) begin
      if (r1 && r2) begin
        m_rally = 0;
      end else if (r1) begin
        m_s1++;
        m_rally = 0;
        if (m_s1 == WIN) begin m_won = 1; m_pending = 1; end
      end else if (r2) begin
        m_s2++;
        m_rally = 0;
        if (m_s2 == WIN) begin m_won = 1; m_pending = 2; end
      end
    end else if (f) begin
      if (m_frames == PAUSE - 1) begin
        m_frames = 0;
        m_rally = 1;
      end else begin
        m_frames++;
      end
    end
    m_pg1 = a; m_pg2 = b; m_prs = r;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit f, input bit a, input bit b, input bit r);
    int e_serve;
    ft = f; g1 = a; g2 = b; rs = r;
    e_serve = (!m_rally && !m_won && f && m_frames == PAUSE - 1) ? 1 : 0;
    @(negedge clk);
    check("score_p1", s_p1, m_s1);
    check("score_p2", s_p2, m_s2);
    check("serve", serve_w, e_serve);
    check("game_active", active_w, m_rally ? 1 : 0);
    check("p1w", p1w_w, (m_shown == 1) ? 1 : 0);
    check("p2w", p2w_w, (m_shown == 2) ? 1 : 0);
    check("winner_exclusive", p1w_w & p2w_w, 0);
    if (serve_w === 1'b1) serve_seen++;
    model_advance(f, a, b, r);
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic serve_wait();
    for (int i = 0; i < 200 && active_w !== 1'b1; i++) frames(1);
    check("serve_wait_active", active_w, 1);
  endtask

  task automatic goal(input int who);
    step(0, who == 1, who == 2, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic apply_reset();
    ft = 0; g1 = 0; g2 = 0; rs = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_score_p1", s_p1, 0);
    check("rst_score_p2", s_p2, 0);
    check("rst_serve", serve_w, 0);
    check("rst_active", active_w, 0);
    check("rst_p1w", p1w_w, 0);
    check("rst_p2w", p2w_w, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit rf, ra, rb, rr;
    model_reset();

    // Power-on reset values.
    #7;
    check("por_score_p1", s_p1, 0);
    check("por_score_p2", s_p2, 0);
    check("por_serve", serve_w, 0);
    check("por_active", active_w, 0);
    check("por_p1w", p1w_w, 0);
    check("por_p2w", p2w_w, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Serve comes on the 60th frame tick, play starts the next cycle.
    serve_seen = 0;
    frames(PAUSE - 1);
    check("t1_no_early_serve", serve_seen, 0);
    step(1, 0, 0, 0);
    check("t1_serve_once", serve_seen, 1);
    check("t1_active_next", active_w, 1);

    // A goal level held for 500 cycles scores once.
    repeat (500) step(0, 1, 0, 0);
    check("t2_score_p1", s_p1, 1);
    check("t2_active_low", active_w, 0);
    step(0, 0, 0, 0);

    // Simultaneous goals: dead ball.
    serve_wait();
    step(0, 1, 1, 0);
    step(0, 0, 0, 0);
    check("t3_score_p1", s_p1, 1);
    check("t3_score_p2", s_p2, 0);
    check("t3_active_low", active_w, 0);

    // P2 wins; overlay waits for the next frame tick.
    repeat (WIN) begin
      serve_wait();
      goal(2);
    end
    check("t4_score_p2", s_p2, WIN);
    check("t4_p2w_before_tick", p2w_w, 0);
    step(1, 0, 0, 0);
    check("t4_p2w_after_tick", p2w_w, 1);
    check("t4_p1w", p1w_w, 0);
    goal(2);
    goal(1);
    check("t4_score_p2_held", s_p2, WIN);
    check("t4_score_p1_held", s_p1, 1);

    // Early restart dropped; late restart clears and a serve follows.
    frames(9);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("t5_early_restart_ignored", s_p2, WIN);
    frames(OVER);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("t5_restart_score_p2", s_p2, 0);
    check("t5_restart_score_p1", s_p1, 0);
    check("t5_p2w_until_tick", p2w_w, 1);
    serve_seen = 0;
    step(1, 0, 0, 0);
    check("t5_p2w_cleared", p2w_w, 0);
    step(0, 0, 0, 0);
    frames(PAUSE - 2);
    check("t5_no_early_serve", serve_seen, 0);
    step(1, 0, 0, 0);
    check("t5_serve_after_60", serve_seen, 1);

    // Reach 3:5, then reset during play.
    repeat (3) begin serve_wait(); goal(1); end
    repeat (5) begin serve_wait(); goal(2); end
    serve_wait();
    check("t6_score_p1", s_p1, 3);
    check("t6_score_p2", s_p2, 5);
    apply_reset();

    // Randomized play against the model.
    ra = 0; rb = 0; rr = 0;
    for (int c = 0; c < 20000; c++) begin
      rf = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) ra = !ra;
      if ($urandom_range(0, 19) == 0) rb = !rb;
      if ($urandom_range(0, 39) == 0) rr = !rr;
      if ($urandom_range(0, 9999) == 0) begin
        apply_reset();
        ra = 0; rb = 0; rr = 0;
      end else begin
        step(rf, ra, rb, rr);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
